segment_queue: RTL

//  Producer side of the segment data_available/data_request interface. Collects a host byte

---
 rtl/segment_pkg.sv | 9 +
 rtl/segment_queue_fifo.sv | 59 +++++
 rtl/segment_queue.sv | 79 +++++++
 3 files changed

// File: rtl/segment_pkg.sv
// segment_pkg: shared segment word definitions for the segment queue and its consumer
//   SEGMENT_READ_BYTES : bytes per segment word
//   SEGMENT_DEPTH      : default FIFO depth
//   segment_word_t     : little-endian segment word
package segment_pkg;
   localparam int SEGMENT_READ_BYTES = 4;
   localparam int SEGMENT_DEPTH = 16;
   typedef logic [8*SEGMENT_READ_BYTES-1:0] segment_word_t;
endpackage

// File: rtl/segment_queue_fifo.sv
// segment_fifo: Depth x Width register-array FIFO with head read and level count
//   clk, rst_n : clock, async active-low reset (clears pointers, count and memory)
//   flush      : sync clear of pointers and count, wins over push/pop
//   push/wdata : write wdata at tail when not full
//   pop        : advance head when not empty
//   rdata      : head word (mem[rd_ptr])
//   empty/full : from registered count
//   count      : registered entry count 0..Depth
module segment_fifo
   import segment_pkg::*;
#(
   parameter int Depth = SEGMENT_DEPTH,
   parameter int Width = $bits(segment_word_t),
   localparam int PtrBits = $clog2(Depth),
   localparam int LevelBits = PtrBits + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 push,
   input  logic [Width-1:0]     wdata,
   input  logic                 pop,
   output logic [Width-1:0]     rdata,
   output logic                 empty,
   output logic                 full,
   output logic [LevelBits-1:0] count
);
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrBits-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [LevelBits-1:0] cnt_q, cnt_d;
   logic push_ok, pop_ok;
   assign empty = cnt_q == '0;
   assign full = cnt_q == LevelBits'(Depth);
   assign push_ok = push & ~full;
   assign pop_ok = pop & ~empty;
   assign rdata = mem_q[rd_q];
   assign count = cnt_q;
   always_comb begin
      mem_d = mem_q;
      if (push_ok && !flush) mem_d[wr_q] = wdata;
      wr_d = flush ? '0 : wr_q + PtrBits'(push_ok);
      rd_d = flush ? '0 : rd_q + PtrBits'(pop_ok);
      cnt_d = flush ? '0 : cnt_q + LevelBits'(push_ok) - LevelBits'(pop_ok);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/segment_queue.sv
// segment_queue: assembles a host byte stream into little-endian segment words and queues them
//   clk, rst_n      : clock, async active-low reset
//   flush           : sync clear of FIFO, assembler and underflow flag
//   in_valid/in_ready/in_byte : byte stream, first byte -> word bits [7:0]
//   data_available  : FIFO non-empty, data holds head word
//   data_request    : one-cycle pop pulse from consumer
//   data            : head word
//   underflow       : sticky, pop seen while empty
//   level           : entry count, present only with SEGMENT_QUEUE_LEVEL_EN
module segment_queue
   import segment_pkg::*;
#(
   parameter int ReadBytes = SEGMENT_READ_BYTES,
   parameter int Depth = SEGMENT_DEPTH,
   localparam int LevelBits = $clog2(Depth) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_byte,
   output logic                   data_available,
   input  logic                   data_request,
   output logic [8*ReadBytes-1:0] data,
   output logic                   underflow
`ifdef SEGMENT_QUEUE_LEVEL_EN
   ,
   output logic [LevelBits-1:0]   level
`endif
);
   localparam int IdxBits = $clog2(ReadBytes);
   localparam logic [IdxBits-1:0] Last = IdxBits'(ReadBytes - 1);
   logic [IdxBits-1:0] idx_q, idx_d;
   logic [8*(ReadBytes-1)-1:0] hold_q, hold_d;
   logic underflow_q, underflow_d;
   logic accept, push, empty, full, last;
   logic [LevelBits-1:0] count;
   assign last = idx_q == Last;
   // registered full only: a pop in the same cycle does not reopen the input
   assign in_ready = ~last | ~full;
   assign accept = in_valid & in_ready;
   assign push = accept & last;
   assign data_available = ~empty;
   assign underflow = underflow_q;
`ifdef SEGMENT_QUEUE_LEVEL_EN
   assign level = count;
`endif
   segment_fifo #(.Depth(Depth), .Width(8*ReadBytes)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .wdata ({in_byte, hold_q}),
      .pop   (data_request),
      .rdata (data),
      .empty (empty),
      .full  (full),
      .count (count)
   );
   always_comb begin
      hold_d = hold_q;
      if (flush) hold_d = '0;
      else if (accept && !last) hold_d[idx_q*8 +: 8] = in_byte;
      idx_d = flush ? '0 : accept ? (last ? '0 : idx_q + 1'b1) : idx_q;
      underflow_d = flush ? 1'b0 : underflow_q | (data_request & empty);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         hold_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         hold_q <= hold_d;
         underflow_q <= underflow_d;
      end
   end
endmodule
